// File: rtl/expr_eval.sv
// Streaming ASCII expression recogniser/evaluator: one character per accepted cycle,
// '*' binds tighter than '+'/'-', W-bit signed result with sticky overflow and syntax error.
module expr_eval #(
    parameter int unsigned W           = 16,
    parameter bit          MULTI_DIGIT = 1'b1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                flush,
    input  logic [7:0]          in,
    input  logic                in_valid,
    output logic                out,
    output logic signed [W-1:0] result,
    output logic                err,
    output logic                ovf
);

    typedef enum logic [1:0] {START, OPND, OPER, ERR} state_t;

    localparam logic signed [W+4:0] TEN = (W+5)'(10);

    state_t state, state_n;

    logic signed [W-1:0] sum, prod, cur, result_r;
    logic signed [W-1:0] sum_n, prod_n, cur_n, result_n;
    logic                neg, neg_n, ovf_r, ovf_n;

    logic                is_dig, is_op, is_mul, is_sub;
    logic [3:0]          d;
    logic signed [W+4:0] cur_x;
    logic signed [W-1:0] cur_d, p_dig, p_op;
    logic signed [2*W-1:0] p_dig_x, p_op_x;
    logic signed [W+1:0] s_dig_x, s_op_x;
    logic                ovf_cur, ovf_pd, ovf_sd, ovf_po, ovf_so;

    // Exact-width datapath: each intermediate is wide enough to hold the true value,
    // so overflow is simply "upper bits are not a sign extension of bit W-1".
    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_mul = (in == 8'h2A);
        is_sub = (in == 8'h2D);
        is_op  = is_mul || is_sub || (in == 8'h2B);
        d      = in[3:0];

        cur_x   = $signed({{5{cur[W-1]}}, cur}) * TEN + $signed({{(W+1){1'b0}}, d});
        ovf_cur = MULTI_DIGIT && (cur_x[W+4:W-1] != '0) && (cur_x[W+4:W-1] != '1);
        cur_d   = MULTI_DIGIT ? cur_x[W-1:0] : W'(d);

        p_dig_x = $signed({{W{prod[W-1]}}, prod}) * $signed({{W{cur_d[W-1]}}, cur_d});
        p_dig   = p_dig_x[W-1:0];
        ovf_pd  = (p_dig_x[2*W-1:W-1] != '0) && (p_dig_x[2*W-1:W-1] != '1);
        s_dig_x = neg ? $signed({{2{sum[W-1]}}, sum}) - $signed({{2{p_dig[W-1]}}, p_dig})
                      : $signed({{2{sum[W-1]}}, sum}) + $signed({{2{p_dig[W-1]}}, p_dig});
        ovf_sd  = (s_dig_x[W+1:W-1] != '0) && (s_dig_x[W+1:W-1] != '1);

        p_op_x  = $signed({{W{prod[W-1]}}, prod}) * $signed({{W{cur[W-1]}}, cur});
        p_op    = p_op_x[W-1:0];
        ovf_po  = (p_op_x[2*W-1:W-1] != '0) && (p_op_x[2*W-1:W-1] != '1);
        s_op_x  = neg ? $signed({{2{sum[W-1]}}, sum}) - $signed({{2{p_op[W-1]}}, p_op})
                      : $signed({{2{sum[W-1]}}, sum}) + $signed({{2{p_op[W-1]}}, p_op});
        ovf_so  = (s_op_x[W+1:W-1] != '0) && (s_op_x[W+1:W-1] != '1);
    end

    always_comb begin
        state_n  = state;
        sum_n    = sum;
        prod_n   = prod;
        cur_n    = cur;
        neg_n    = neg;
        result_n = result_r;
        ovf_n    = ovf_r;
        if (in_valid && state != ERR) begin
            if (is_dig) begin
                ovf_n = ovf_r || ovf_cur || ovf_pd || ovf_sd;
                if (state == OPND && !MULTI_DIGIT) begin
                    state_n  = ERR;
                    result_n = '0;
                end else begin
                    state_n  = OPND;
                    cur_n    = cur_d;
                    result_n = s_dig_x[W-1:0];
                end
            end else if (is_op) begin
                ovf_n = ovf_r || ovf_po || (!is_mul && ovf_so);
                if (state == OPND) begin
                    state_n = OPER;
                    cur_n   = '0;
                    if (is_mul) begin
                        prod_n = p_op;
                    end else begin
                        sum_n  = s_op_x[W-1:0];
                        prod_n = W'(1);
                        neg_n  = is_sub;
                    end
                end else begin
                    state_n  = ERR;
                    result_n = '0;
                end
            end else begin
                state_n  = ERR;
                result_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= START;
            sum      <= '0;
            prod     <= W'(1);
            cur      <= '0;
            neg      <= 1'b0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else if (flush) begin
            state    <= START;
            sum      <= '0;
            prod     <= W'(1);
            cur      <= '0;
            neg      <= 1'b0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            state    <= state_n;
            sum      <= sum_n;
            prod     <= prod_n;
            cur      <= cur_n;
            neg      <= neg_n;
            result_r <= result_n;
            ovf_r    <= ovf_n;
        end
    end

    assign out    = (state == OPND);
    assign err    = (state == ERR);
    assign result = result_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboarded bench for expr_eval: three configurations share one character stream,
// an integer reference model predicts each, expectations are queued and checked after every edge.
module tb_expr_eval;

    logic               clk = 1'b0;
    logic               clr_n, flush, in_valid;
    logic [7:0]         in;
    logic               out0, err0, ovf0, out1, err1, ovf1, out2, err2, ovf2;
    logic signed [15:0] res0, res1;
    logic signed [7:0]  res2;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    expr_eval #(.W(16), .MULTI_DIGIT(1'b0)) dut0 (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in(in), .in_valid(in_valid),
        .out(out0), .result(res0), .err(err0), .ovf(ovf0));
    expr_eval #(.W(16), .MULTI_DIGIT(1'b1)) dut1 (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in(in), .in_valid(in_valid),
        .out(out1), .result(res1), .err(err1), .ovf(ovf1));
    expr_eval #(.W(8), .MULTI_DIGIT(1'b1)) dut2 (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in(in), .in_valid(in_valid),
        .out(out2), .result(res2), .err(err2), .ovf(ovf2));

    typedef struct {
        int     k;
        bit     o;
        longint r;
        bit     e;
        bit     v;
    } exp_t;

    exp_t sb[$];

    int     cfg_w[3]  = '{16, 16, 8};
    bit     cfg_md[3] = '{1'b0, 1'b1, 1'b1};
    int     mst[3];   // 0 START, 1 OPND, 2 OPER, 3 ERR
    longint msum[3], mprod[3], mcur[3], mres[3];
    bit     mneg[3], movf[3];

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic longint wrap(input longint x, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = x & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic bit oor(input longint x, input int w);
        longint h;
        h = longint'(1) << (w - 1);
        return (x < -h) || (x > h - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mst[k] = 0; msum[k] = 0; mprod[k] = 1; mcur[k] = 0;
            mneg[k] = 0; mres[k] = 0; movf[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [7:0] c);
        int     w;
        longint dv, cn, p, pw, s;
        w = cfg_w[k];
        if (mst[k] == 3) return;
        if (c >= 8'h30 && c <= 8'h39) begin
            dv = longint'(c) - 48;
            if (cfg_md[k]) begin
                s = mcur[k] * 10 + dv;
                if (oor(s, w)) movf[k] = 1;
                cn = wrap(s, w);
            end else begin
                cn = dv;
            end
            p = mprod[k] * cn;
            if (oor(p, w)) movf[k] = 1;
            pw = wrap(p, w);
            s = mneg[k] ? msum[k] - pw : msum[k] + pw;
            if (oor(s, w)) movf[k] = 1;
            if (mst[k] == 1 && !cfg_md[k]) begin
                mst[k] = 3; mres[k] = 0;
            end else begin
                mst[k] = 1; mcur[k] = cn; mres[k] = wrap(s, w);
            end
        end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A) begin
            p = mprod[k] * mcur[k];
            if (oor(p, w)) movf[k] = 1;
            pw = wrap(p, w);
            s = mneg[k] ? msum[k] - pw : msum[k] + pw;
            if (c != 8'h2A && oor(s, w)) movf[k] = 1;
            if (mst[k] == 1) begin
                mst[k] = 2;
                mcur[k] = 0;
                if (c == 8'h2A) begin
                    mprod[k] = pw;
                end else begin
                    msum[k] = wrap(s, w); mprod[k] = 1; mneg[k] = (c == 8'h2D);
                end
            end else begin
                mst[k] = 3; mres[k] = 0;
            end
        end else begin
            mst[k] = 3; mres[k] = 0;
        end
    endtask

    task automatic push_all();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.k = k; e.o = (mst[k] == 1); e.r = mres[k]; e.e = (mst[k] == 3); e.v = movf[k];
            sb.push_back(e);
        end
    endtask

    task automatic obs(input int k, output bit o, output longint r, output bit e, output bit v);
        case (k)
            0:       begin o = out0; r = longint'(res0); e = err0; v = ovf0; end
            1:       begin o = out1; r = longint'(res1); e = err1; v = ovf1; end
            default: begin o = out2; r = longint'(res2); e = err2; v = ovf2; end
        endcase
    endtask

    task automatic compare_all();
        exp_t   e;
        bit     o, er, v;
        longint r;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs(e.k, o, r, er, v);
            check($sformatf("d%0d.out", e.k), longint'(o), longint'(e.o));
            check($sformatf("d%0d.result", e.k), r, e.r);
            check($sformatf("d%0d.err", e.k), longint'(er), longint'(e.e));
            check($sformatf("d%0d.ovf", e.k), longint'(v), longint'(e.v));
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in = c;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) model_step(k, c);
        push_all();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compare_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in = 8'($urandom);
            in_valid = 1'b0;
            push_all();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    // Character presented alongside flush must be dropped.
    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        in = 8'h37;
        model_reset();
        push_all();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out0"}, longint'(out0), 0);
        check({tag, ".res0"}, longint'(res0), 0);
        check({tag, ".res1"}, longint'(res1), 0);
        check({tag, ".res2"}, longint'(res2), 0);
        check({tag, ".err2"}, longint'(err2), 0);
        check({tag, ".ovf2"}, longint'(ovf2), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check_zero("async_rst");
        #1;
        clr_n = 1'b1;
        model_reset();
    endtask

    initial begin
        string cs;
        cs = "0123456789+-*+- x";
        clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in = 8'h00;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        clr_n = 1'b1;

        send_str("1+3*9");
        check("t1.res0", longint'(res0), 28);

        do_flush();
        send_str("1*9+8");
        idle(3);
        check("t2.hold", longint'(res0), 17);
        send_str("+0");
        check("t2.res0", longint'(res0), 17);

        do_flush();
        send_str("12*3-40");
        check("t3.res1", longint'(res1), -4);
        check("t3.err0", longint'(err0), 1);

        do_flush();
        send_str("99*2");
        check("t5.res2", longint'(res2), -58);
        check("t5.ovf2", longint'(ovf2), 1);
        send_str("+1");

        do_flush();
        send_str("5*");
        pulse_reset();
        send_str("7");
        check("t6.res0", longint'(res0), 7);

        send_str("+");
        idle(4);
        send_str("4");

        do_flush();
        send_str("007-99999*2");
        do_flush();
        send_str("3 ");
        do_flush();
        send_str("*1");
        do_flush();
        send_str("9*9*9*9*9*9-8");

        do_flush();
        repeat (400) begin
            case ($urandom_range(0, 24))
                0:       do_flush();
                1:       idle(1);
                default: send(cs[$urandom_range(0, cs.len() - 1)]);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming ASCII arithmetic-expression recogniser and evaluator; parametrised successor to the single-digit `+`/`*` string recogniser in the P1 front-end. It consumes one character per accepted cycle and flags whether the prefix received so far is a valid expression. It also computes that prefix's value with `*` binding tighter than `+`/`-`. Signed result width and multi-digit operands are build-time selectable. The block sits after the character source and feeds the checker/display stage.

## Interface
- `W`, default 16: result width; signed two's complement.
- `MULTI_DIGIT`, default 1: 1 = operands are decimal digit strings; 0 = single-digit operands only, as in the previous generation.
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear; same effect as reset; has priority over `in_valid`.
- `in`  in  8  ASCII character.
- `in_valid`  in  1  `in` is accepted at this rising edge.
- `out`  out  1  accepted prefix is a valid expression.
- `result`  out  W  value of the accepted prefix; meaningful only when `out`=1.
- `err`  out  1  sticky syntax error.
- `ovf`  out  1  sticky arithmetic overflow.

## Operation
- Character classes:
  - digit: `"0"`–`"9"`, value d = in − 8'h30.
  - op: `"+"`, `"-"`, `"*"`.
  - other: everything else, including space.
- FSM states: START (nothing accepted), OPND (last accepted character was a digit), OPER (last accepted character was an op), ERR.
- FSM transitions, on accepted characters only:
  - START: digit → OPND; anything else → ERR.
  - OPND: digit → OPND if MULTI_DIGIT=1, else ERR; op → OPER; other → ERR.
  - OPER: digit → OPND; anything else → ERR.
  - ERR: stays in ERR until `flush` or reset.
- Output decodes: `out` = (state==OPND); `err` = (state==ERR).
- Evaluation registers, all W-bit signed:
  - `sum`: completed additive terms; reset value 0.
  - `prod`: product of closed factors in the current term; reset value 1.
  - `cur`: operand being built; reset value 0.
  - `neg`: sign of the current term; reset value 0.
- Digit accepted:
  - cur' = MULTI_DIGIT ? cur*10+d : d.
  - result ← sum + (neg ? −prod*cur' : prod*cur').
- `*` accepted: prod ← prod*cur; cur ← 0.
- `+`/`-` accepted:
  - sum ← sum ± prod*cur, with the sign taken from `neg`.
  - prod ← 1; cur ← 0.
  - neg ← (op=="-").
- Op accepted: `result` holds its last value.
- Entry to ERR: `result` ← 0; evaluation registers freeze.
- Arithmetic is modulo 2^W. `ovf` is set when the exact mathematical value of any of these is outside [−2^(W−1), 2^(W−1)−1]:
  - cur*10+d;
  - any product formed;
  - any sum formed.
- `ovf` stays set until `flush` or reset; the wrapped value is still stored.
- `in_valid`=0: all state holds.
- Reset or `flush`: state = START; evaluation registers take their reset values; `out`=0, `result`=0, `err`=0, `ovf`=0.

## Timing
- Latency: `out`, `result`, `err` and `ovf` update at the same rising edge that accepts the character, with no extra pipeline stage.
- Throughput: one character per cycle with no stall. Multiply and add are single-cycle combinational paths.
- `clr_n` low forces all outputs to reset values immediately, independent of `clk`. Reset mid-expression discards the partial expression. The first accepted character after `clr_n` rises is treated as being in START.
- `flush` and `in_valid` high in the same cycle: `flush` wins and the character is dropped.
- Overflow and syntax error in the same cycle: the state goes to ERR and `ovf` is also set.
- MULTI_DIGIT=1, leading zeros: `"007"` is legal and evaluates to 7.

## Test plan
1. W=16, MULTI_DIGIT=0, one character per cycle, `"1+3*9"`:
   - `out` = 1,0,1,0,1;
   - `result` = 1,1,4,4,28 after each edge;
   - `err`=`ovf`=0.
2. Apply `flush`, then `"1*9+8"`, idle 3 cycles, then `"+0"`:
   - `result` = 1,1,9,9,17;
   - `result` holds 17 and `out`=1 through the idle cycles;
   - after `"+"`: `out`=0;
   - after `"0"`: `result`=17, `out`=1.
3. MULTI_DIGIT=1, `"12*3-40"`:
   - `result` after the final digit is −4 (16'hFFFC);
   - `out`=1.
4. MULTI_DIGIT=0, `"12"`:
   - after the second digit: `err`=1, `out`=0, `result`=0;
   - following `"+5"` does not change any output;
   - after `flush`: `err`=0.
5. W=8, `"99*2"`:
   - `ovf` is 0 after `"99"` (result 99);
   - `ovf`=1 after `"2"`, `result`=8'hC6, `out`=1;
   - `ovf` is still set after a further `"+1"`.
6. Reset mid-operation:
   - `"5*"` accepted, then `clr_n` pulsed low between clock edges: outputs reach 0 before the next edge;
   - next `"7"` gives `result`=7, not 35.
7. `in_valid` held low with garbage on `in` for 4 cycles: no state or output change.
